kyber_butterfly: RTL and testbench
==================================

Name: kyber_butterfly

Overview:
- Pipelined radix-2 butterfly for Kyber NTT/INTT over Z_q, with q = 3329 and 12-bit coefficients.
- Sits inside the polynomial-multiplier datapath and is fed by the coefficient memory and the twiddle ROM.
- Two modes, selected per input sample:
  - Cooley-Tukey (CT, forward NTT)
  - Gentleman-Sande (GS, inverse NTT)
- The internal modular multiplier, adder and subtractor results are exported as tap outputs for debug.

Parameters:
- Q, 3329, modulus. Fixed; other values are unsupported.
- DW, 12, coefficient width.
- BARRETT_M, 5039, floor(2^24/Q), the Barrett constant with k = 24.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- CT  in  1  mode select: 1 = CT butterfly, 0 = GS butterfly. Sampled with A/B/W.
- A  in  12  even coefficient, range 0..Q-1.
- B  in  12  odd coefficient, range 0..Q-1.
- W  in  12  twiddle factor, range 0..Q-1.
- E  out  12  even result.
- O  out  12  odd result.
- MUL  out  12  modular multiplier output register.
- ADD  out  12  modular adder output register.
- SUB  out  12  modular subtractor output register.

Behaviour:
- Reset:
  - rst low immediately clears every pipeline register, including delayed copies of A, W and CT.
  - E, O, MUL, ADD and SUB all read 0 while rst is low.
  - Reset mid-operation discards all in-flight samples.
  - First valid result appears 4 cycles after the first sample following rst release.
- Streaming operation:
  - A new (CT, A, B, W) is accepted every cycle; there is no handshake and no stall.
  - CT travels down the pipeline with its sample, so the mode may change on every cycle.
- Modular multiplier (fixed 3-cycle latency):
  - Stage 1: 24-bit product.
  - Stage 2: Barrett estimate using BARRETT_M with shift 24.
  - Stage 3: up to two conditional subtractions of Q. Result lies in 0..Q-1.
- Modular add and subtract (1 cycle):
  - Add: x + y, minus Q if the sum is >= Q.
  - Subtract: x - y, plus Q if the difference is negative.
  - Use a 13-bit intermediate.
- CT mode, sample entering at cycle t:
  - MUL = B*W mod Q at t+3.
  - ADD = (A + MUL) mod Q and SUB = (A - MUL) mod Q at t+4, using A delayed 3 cycles.
  - E = ADD, O = SUB.
- GS mode, sample entering at cycle t:
  - ADD = (A + B) mod Q and SUB = (A - B) mod Q at t+1.
  - MUL = SUB*W mod Q at t+4, using W delayed 1 cycle.
  - E = ADD delayed 3 cycles, O = MUL.
- E/O latency is 4 cycles in both modes.
- E/O are driven by a mode mux from registered values; the mux select is CT delayed 4 cycles.
- Tap outputs reflect whichever sample currently occupies each register.
- Out-of-range inputs (>= Q) are not supported; outputs are don't-care and benches must not drive them.

Optional Feature:
- Macro: BUTTERFLY_GS_HALVE_EN.
- When defined, GS-mode E and O are each multiplied by 2^-1 mod Q:
  - x even: x >> 1.
  - x odd: (x + Q) >> 1.
  - The halving is combinational on the output mux path; latency stays 4.
- CT mode and the MUL/ADD/SUB taps are unaffected.
- When undefined, there is no halving and this logic is absent.

Decomposition:
- Shared package kyber_pkg holds:
  - Q, DW, BARRETT_M, the Barrett shift (24), the multiplier latency (3);
  - a coeff_t typedef (logic [11:0]).
- One natural sub-module: kyber_modmul, the 3-stage Barrett multiplier, reused elsewhere in the multiplier.
- Adder, subtractor and delay lines stay inline.

Test Plan:
- Reset: hold rst low with random inputs -> E=O=MUL=ADD=SUB=0 throughout. Release, apply one sample -> first valid E/O after 4 cycles.
- CT, A=874 B=2788 W=187 -> MUL=2032 at +3; E=2906, O=2171 at +4.
- GS, A=874 B=2788 W=187 -> ADD=333, SUB=1415 at +1; MUL=1614 at +4; E=333, O=1614 at +4. With BUTTERFLY_GS_HALVE_EN: E=1831, O=807.
- CT wrap boundary, A=B=W=3328 -> MUL=1, E=0, O=3327. GS with A=0, B=1, W=1 -> E=1, O=3328.
- Back-to-back stream alternating CT/GS every cycle using the two vectors above -> each sample's E/O appears exactly 4 cycles later with its own mode's values.
- Assert rst during a full pipeline -> all outputs 0 asynchronously. No stale results emerge after release.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants, coefficient type and modular add/sub helpers for the Kyber datapath.
// The GS halving helper exists only when BUTTERFLY_GS_HALVE_EN is defined.
package kyber_pkg;

  localparam int unsigned Q         = 3329;
  localparam int unsigned DW        = 12;
  localparam int unsigned BARRETT_M = 5039;
  localparam int unsigned BARRETT_K = 24;
  localparam int unsigned MUL_LAT   = 3;

  typedef logic [DW-1:0] coeff_t;

  // Single conditional correction is enough since both operands are below Q.
  function automatic coeff_t mod_add(input coeff_t x, input coeff_t y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= (DW+1)'(Q)) s = s - (DW+1)'(Q);
    return coeff_t'(s);
  endfunction

  // Top bit of the 13-bit difference flags a borrow.
  function automatic coeff_t mod_sub(input coeff_t x, input coeff_t y);
    logic [DW:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[DW]) d = d + (DW+1)'(Q);
    return coeff_t'(d);
  endfunction

`ifdef BUTTERFLY_GS_HALVE_EN
  // Multiply by 2^-1 mod Q: odd values are made even by adding Q first.
  function automatic coeff_t mod_half(input coeff_t x);
    logic [DW:0] h;
    h = {1'b0, x} + (x[0] ? (DW+1)'(Q) : (DW+1)'(0));
    return coeff_t'(h >> 1);
  endfunction
`endif

endpackage

// File: rtl/kyber_modmul.sv
// Three-stage Barrett modular multiplier mod Q: product, quotient estimate, final correction.
module kyber_modmul
  import kyber_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] p
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned EW = PW + 13;
  localparam int unsigned RW = DW + 2;

  logic [PW-1:0] prod_q;
  logic [RW-1:0] rem_q;
  logic [EW-1:0] est_full;
  logic [DW-1:0] qhat;
  logic [PW-1:0] rem_full;
  logic [RW-1:0] r1;
  logic [RW-1:0] r2;

  // Estimate undershoots the true quotient by at most 2, so the remainder is below 3Q.
  always_comb begin
    est_full = EW'(prod_q) * EW'(BARRETT_M);
    qhat     = DW'(est_full >> BARRETT_K);
    rem_full = prod_q - PW'(qhat) * PW'(Q);
  end

  always_comb begin
    r1 = rem_q;
    if (rem_q >= RW'(Q)) r1 = rem_q - RW'(Q);
    r2 = r1;
    if (r1 >= RW'(Q)) r2 = r1 - RW'(Q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      rem_q  <= '0;
      p      <= '0;
    end else begin
      prod_q <= PW'(a) * PW'(b);
      rem_q  <= RW'(rem_full);
      p      <= DW'(r2);
    end
  end

endmodule

// File: rtl/kyber_butterfly.sv
// Pipelined CT/GS radix-2 butterfly over Z_3329 with 4-cycle E/O latency and debug taps.
// Optional BUTTERFLY_GS_HALVE_EN scales GS-mode E/O by 2^-1 mod Q on the output mux.
module kyber_butterfly
  import kyber_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          CT,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] W,
  output logic [DW-1:0] E,
  output logic [DW-1:0] O,
  output logic [DW-1:0] MUL,
  output logic [DW-1:0] ADD,
  output logic [DW-1:0] SUB
);

  logic [3:0]    ct_d;
  logic [DW-1:0] a_d1, a_d2, a_d3;
  logic [DW-1:0] w_d1;
  logic [DW-1:0] add_gs, sub_gs;
  logic [DW-1:0] add_gs_d1, add_gs_d2, add_gs_d3;
  logic [DW-1:0] add_ct, sub_ct;
  logic [DW-1:0] mul_ct, mul_gs;
  logic [DW-1:0] e_gs, o_gs;

  // Separate CT and GS multipliers so the mode can switch every cycle without contention.
  kyber_modmul u_mul_ct (
    .clk   (clk),
    .rst_n (rst),
    .a     (B),
    .b     (W),
    .p     (mul_ct)
  );

  kyber_modmul u_mul_gs (
    .clk   (clk),
    .rst_n (rst),
    .a     (sub_gs),
    .b     (w_d1),
    .p     (mul_gs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ct_d      <= '0;
      a_d1      <= '0;
      a_d2      <= '0;
      a_d3      <= '0;
      w_d1      <= '0;
      add_gs    <= '0;
      sub_gs    <= '0;
      add_gs_d1 <= '0;
      add_gs_d2 <= '0;
      add_gs_d3 <= '0;
      add_ct    <= '0;
      sub_ct    <= '0;
    end else begin
      ct_d      <= {ct_d[2:0], CT};
      a_d1      <= A;
      a_d2      <= a_d1;
      a_d3      <= a_d2;
      w_d1      <= W;
      add_gs    <= mod_add(A, B);
      sub_gs    <= mod_sub(A, B);
      add_gs_d1 <= add_gs;
      add_gs_d2 <= add_gs_d1;
      add_gs_d3 <= add_gs_d2;
      add_ct    <= mod_add(a_d3, mul_ct);
      sub_ct    <= mod_sub(a_d3, mul_ct);
    end
  end

  always_comb begin
    e_gs = add_gs_d3;
    o_gs = mul_gs;
`ifdef BUTTERFLY_GS_HALVE_EN
    e_gs = mod_half(add_gs_d3);
    o_gs = mod_half(mul_gs);
`endif
  end

  // ct_d[3] tags the sample at the output stage, ct_d[2] the one leaving the CT multiplier.
  always_comb begin
    E   = ct_d[3] ? add_ct : e_gs;
    O   = ct_d[3] ? sub_ct : o_gs;
    MUL = ct_d[2] ? mul_ct : mul_gs;
    ADD = ct_d[3] ? add_ct : add_gs;
    SUB = ct_d[3] ? sub_ct : sub_gs;
  end

endmodule

// File: tb/tb_kyber_butterfly.sv
// Self-checking bench for kyber_butterfly: directed vectors plus random CT/GS streams vs a Z_q model.
module tb_kyber_butterfly;

  localparam int QM = 3329;

  logic        clk;
  logic        rst;
  logic        CT;
  logic [11:0] A, B, W;
  logic [11:0] E, O, MUL, ADD, SUB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit ct;
    int a;
    int b;
    int w;
  } samp_t;

  samp_t hist[$];

  kyber_butterfly dut (
    .clk (clk),
    .rst (rst),
    .CT  (CT),
    .A   (A),
    .B   (B),
    .W   (W),
    .E   (E),
    .O   (O),
    .MUL (MUL),
    .ADD (ADD),
    .SUB (SUB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int zmul(input int x, input int y);
    return (x * y) % QM;
  endfunction

  function automatic int zadd(input int x, input int y);
    return (x + y) % QM;
  endfunction

  function automatic int zsub(input int x, input int y);
    return (x - y + QM) % QM;
  endfunction

  // Output scaling for GS mode; 1665 is the inverse of 2 mod 3329.
  function automatic int gs_scale(input int x);
`ifdef BUTTERFLY_GS_HALVE_EN
    return (x * 1665) % QM;
`else
    return x;
`endif
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, QM - 1));
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_history();
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back('{1'b0, 0, 0, 0});
  endtask

  // Compare outputs against the model for the samples now in flight.
  task automatic check_model();
    samp_t s0, s1, s2, s3;
    int n, m, e_exp, o_exp;
    n  = hist.size();
    s0 = hist[n-1];
    s1 = hist[n-2];
    s2 = hist[n-3];
    s3 = hist[n-4];
    if (s3.ct) begin
      m     = zmul(s3.b, s3.w);
      e_exp = zadd(s3.a, m);
      o_exp = zsub(s3.a, m);
    end else begin
      e_exp = gs_scale(zadd(s3.a, s3.b));
      o_exp = gs_scale(zmul(zsub(s3.a, s3.b), s3.w));
    end
    check("E", E, 12'(e_exp));
    check("O", O, 12'(o_exp));
    if (s0.ct == s1.ct && s1.ct == s2.ct && s2.ct == s3.ct) begin
      if (s0.ct) begin
        check("MUL_ct", MUL, 12'(zmul(s2.b, s2.w)));
        check("ADD_ct", ADD, 12'(zadd(s3.a, zmul(s3.b, s3.w))));
        check("SUB_ct", SUB, 12'(zsub(s3.a, zmul(s3.b, s3.w))));
      end else begin
        check("MUL_gs", MUL, 12'(zmul(zsub(s3.a, s3.b), s3.w)));
        check("ADD_gs", ADD, 12'(zadd(s0.a, s0.b)));
        check("SUB_gs", SUB, 12'(zsub(s0.a, s0.b)));
      end
    end
  endtask

  task automatic tick(input bit ct, input int a, input int b, input int w);
    CT = ct;
    A  = 12'(a);
    B  = 12'(b);
    W  = 12'(w);
    hist.push_back('{ct, a, b, w});
    if (hist.size() > 8) void'(hist.pop_front());
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic tick_rnd(input bit ct);
    tick(ct, rnd(), rnd(), rnd());
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_E"}, E, 12'd0);
    check({tag, "_O"}, O, 12'd0);
    check({tag, "_MUL"}, MUL, 12'd0);
    check({tag, "_ADD"}, ADD, 12'd0);
    check({tag, "_SUB"}, SUB, 12'd0);
  endtask

  task automatic rst_tick();
    CT = 1'($urandom_range(0, 1));
    A  = 12'(rnd());
    B  = 12'(rnd());
    W  = 12'(rnd());
    @(posedge clk);
    #1;
    check_zero("rst_hold");
  endtask

  initial begin
    rst = 1'b0;
    CT  = 1'b0;
    A   = '0;
    B   = '0;
    W   = '0;

    // Held in reset with random inputs.
    for (int i = 0; i < 4; i++) rst_tick();

    // Release and stream CT samples; first valid E/O lands 4 cycles after the first sample.
    rst = 1'b1;
    reset_history();
    for (int i = 0; i < 8; i++) tick_rnd(1'b1);

    // CT directed vector.
    tick(1'b1, 874, 2788, 187);
    tick_rnd(1'b1);
    tick_rnd(1'b1);
    check("ct_vec_MUL", MUL, 12'd2032);
    tick_rnd(1'b1);
    check("ct_vec_E", E, 12'd2906);
    check("ct_vec_O", O, 12'd2171);

    // GS directed vector.
    for (int i = 0; i < 4; i++) tick_rnd(1'b0);
    tick(1'b0, 874, 2788, 187);
    check("gs_vec_ADD", ADD, 12'd333);
    check("gs_vec_SUB", SUB, 12'd1415);
    tick_rnd(1'b0);
    tick_rnd(1'b0);
    tick_rnd(1'b0);
    check("gs_vec_MUL", MUL, 12'd1614);
`ifdef BUTTERFLY_GS_HALVE_EN
    check("gs_vec_E", E, 12'd1831);
    check("gs_vec_O", O, 12'd807);
`else
    check("gs_vec_E", E, 12'd333);
    check("gs_vec_O", O, 12'd1614);
`endif

    // CT wrap boundary.
    tick(1'b1, 3328, 3328, 3328);
    tick_rnd(1'b1);
    tick_rnd(1'b1);
    check("ct_wrap_MUL", MUL, 12'd1);
    tick_rnd(1'b1);
    check("ct_wrap_E", E, 12'd0);
    check("ct_wrap_O", O, 12'd3327);

    // GS negative-difference boundary.
    for (int i = 0; i < 4; i++) tick_rnd(1'b0);
    tick(1'b0, 0, 1, 1);
    check("gs_edge_SUB", SUB, 12'd3328);
    tick_rnd(1'b0);
    tick_rnd(1'b0);
    tick_rnd(1'b0);
`ifdef BUTTERFLY_GS_HALVE_EN
    check("gs_edge_E", E, 12'd1665);
    check("gs_edge_O", O, 12'd1664);
`else
    check("gs_edge_E", E, 12'd1);
    check("gs_edge_O", O, 12'd3328);
`endif

    // Alternate modes every cycle with the two reference vectors.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) tick(1'b1, 874, 2788, 187);
      else            tick(1'b0, 874, 2788, 187);
    end

    // Random streams: long single-mode runs then per-cycle random modes.
    for (int i = 0; i < 40; i++) tick_rnd(1'b1);
    for (int i = 0; i < 40; i++) tick_rnd(1'b0);
    for (int i = 0; i < 200; i++) tick_rnd(1'($urandom_range(0, 1)));

    // Asynchronous reset into a full pipeline.
    for (int i = 0; i < 6; i++) tick_rnd(1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < 3; i++) rst_tick();

    // After release nothing stale may appear.
    rst = 1'b1;
    reset_history();
    for (int i = 0; i < 12; i++) tick_rnd(1'b0);
    for (int i = 0; i < 12; i++) tick_rnd(1'b1);

    // Reset during GS traffic, then release straight into CT.
    #2;
    rst = 1'b0;
    #1;
    check_zero("rst_async_gs");
    rst_tick();
    rst = 1'b1;
    reset_history();
    for (int i = 0; i < 10; i++) tick_rnd(1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
